// File: rtl/multi_core_divider_pkg.sv
// Shared definitions for the four-lane divider farm: instruction field
// positions, sizes and the 6-by-4 unsigned divide used by every core.
package multi_core_divider_pkg;

  localparam int DEPTH = 4;
  localparam int IW    = 12;
  localparam int RW    = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  localparam int CORE_HI = 11;
  localparam int CORE_LO = 10;
  localparam int DVD_HI  = 9;
  localparam int DVD_LO  = 4;
  localparam int DVS_HI  = 3;
  localparam int DVS_LO  = 0;

  localparam logic [RW-1:0] DIV_BY_ZERO = 8'hFF;

  // Truncating unsigned divide; a zero divisor yields the saturate flag.
  function automatic logic [RW-1:0] div6by4(input logic [5:0] dividend,
                                            input logic [3:0] divisor);
    logic [5:0]    quo;
    logic [RW-1:0] res;
    if (divisor == 4'd0) begin
      res = DIV_BY_ZERO;
    end else begin
      quo = dividend / {2'b00, divisor};
      res = {2'b00, quo};
    end
    return res;
  endfunction

endpackage

// File: rtl/multi_core_divider_sync_fifo.sv
// Small synchronous FIFO with occupancy count; a push is accepted when full
// only if a pop retires the head in the same cycle.
module multi_core_divider_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/multi_core_divider.sv
// Four-lane divider farm: steers instructions into per-core FIFOs by core id,
// pops when globally enabled and the core is enabled, and registers the
// popped instruction together with its quotient.
module multi_core_divider
  import multi_core_divider_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] instruction,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic [IW-1:0] data_out0,
  output logic [IW-1:0] data_out1,
  output logic [IW-1:0] data_out2,
  output logic [IW-1:0] data_out3,
  output logic [3:0]    data_empty,
  output logic [3:0]    data_full,
  output logic [CW-1:0] fifo_counter0,
  output logic [CW-1:0] fifo_counter1,
  output logic [CW-1:0] fifo_counter2,
  output logic [CW-1:0] fifo_counter3,
  output logic [4:0]    counter,
  output logic          wr_en0,
  output logic          wr_en1,
  output logic          wr_en2,
  output logic          wr_en3,
  output logic [RW-1:0] result0,
  output logic [RW-1:0] result1,
  output logic [RW-1:0] result2,
  output logic [RW-1:0] result3,
  input  logic [7:0]    select,
  output logic [3:0]    clock
);

  logic [3:0]    wr_dec;
  logic [3:0]    pop;
  logic [IW-1:0] fifo_head  [4];
  logic [CW-1:0] fifo_cnt   [4];
  logic [IW-1:0] data_out_r [4];
  logic [RW-1:0] result_r   [4];
  logic          select_unused;

  // Low nibble of select is reserved.
  assign select_unused = ^select[3:0];

  for (genvar n = 0; n < 4; n++) begin : g_core
    assign wr_dec[n] = wr_en && (instruction[CORE_HI:CORE_LO] == 2'(n));
    assign pop[n]    = rd_en && clock[n] && !data_empty[n];

    multi_core_divider_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (IW)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (wr_dec[n]),
      .pop   (pop[n]),
      .din   (instruction),
      .head  (fifo_head[n]),
      .count (fifo_cnt[n]),
      .empty (data_empty[n]),
      .full  (data_full[n])
    );
  end

  // Registered core enables and per-core popped instruction / quotient.
  always_ff @(posedge clk) begin
    if (rst) begin
      clock <= '0;
      for (int n = 0; n < 4; n++) begin
        data_out_r[n] <= '0;
        result_r[n]   <= '0;
      end
    end else begin
      clock <= select[7:4];
      for (int n = 0; n < 4; n++) begin
        if (pop[n]) begin
          data_out_r[n] <= fifo_head[n];
          result_r[n]   <= div6by4(fifo_head[n][DVD_HI:DVD_LO],
                                   fifo_head[n][DVS_HI:DVS_LO]);
        end
      end
    end
  end

  // Total occupancy across all cores.
  always_comb begin
    counter = '0;
    for (int n = 0; n < 4; n++) begin
      counter = counter + {2'b00, fifo_cnt[n]};
    end
  end

  assign wr_en0 = wr_dec[0];
  assign wr_en1 = wr_dec[1];
  assign wr_en2 = wr_dec[2];
  assign wr_en3 = wr_dec[3];

  assign fifo_counter0 = fifo_cnt[0];
  assign fifo_counter1 = fifo_cnt[1];
  assign fifo_counter2 = fifo_cnt[2];
  assign fifo_counter3 = fifo_cnt[3];

  assign data_out0 = data_out_r[0];
  assign data_out1 = data_out_r[1];
  assign data_out2 = data_out_r[2];
  assign data_out3 = data_out_r[3];

  assign result0 = result_r[0];
  assign result1 = result_r[1];
  assign result2 = result_r[2];
  assign result3 = result_r[3];

endmodule

// File: tb/tb_multi_core_divider.sv
// Directed bench for the four-lane divider farm.
module tb_multi_core_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] instruction;
  logic        wr_en;
  logic        rd_en;
  logic [7:0]  select;
  logic [11:0] data_out0, data_out1, data_out2, data_out3;
  logic [3:0]  data_empty, data_full;
  logic [2:0]  fifo_counter0, fifo_counter1, fifo_counter2, fifo_counter3;
  logic [4:0]  counter;
  logic        wr_en0, wr_en1, wr_en2, wr_en3;
  logic [7:0]  result0, result1, result2, result3;
  logic [3:0]  clock;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_core_divider dut (
    .clk           (clk),
    .rst           (rst),
    .instruction   (instruction),
    .wr_en         (wr_en),
    .rd_en         (rd_en),
    .data_out0     (data_out0),
    .data_out1     (data_out1),
    .data_out2     (data_out2),
    .data_out3     (data_out3),
    .data_empty    (data_empty),
    .data_full     (data_full),
    .fifo_counter0 (fifo_counter0),
    .fifo_counter1 (fifo_counter1),
    .fifo_counter2 (fifo_counter2),
    .fifo_counter3 (fifo_counter3),
    .counter       (counter),
    .wr_en0        (wr_en0),
    .wr_en1        (wr_en1),
    .wr_en2        (wr_en2),
    .wr_en3        (wr_en3),
    .result0       (result0),
    .result1       (result1),
    .result2       (result2),
    .result3       (result3),
    .select        (select),
    .clock         (clock)
  );

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; select = 8'h00; instruction = '0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (data_empty !== 4'hF) begin errors++; $display("FAIL reset_empty: got %h want %h", data_empty, 4'hF); end
    checks++;
    if (data_full !== 4'h0) begin errors++; $display("FAIL reset_full: got %h want %h", data_full, 4'h0); end
    checks++;
    if (counter !== 5'd0) begin errors++; $display("FAIL reset_counter: got %0d want 0", counter); end
    checks++;
    if ({result0, result1, result2, result3} !== 32'h0) begin
      errors++; $display("FAIL reset_results: got %h %h %h %h want 0", result0, result1, result2, result3);
    end
    checks++;
    if ({data_out0, data_out1, data_out2, data_out3} !== 48'h0) begin
      errors++; $display("FAIL reset_data_out: got %h %h %h %h want 0", data_out0, data_out1, data_out2, data_out3);
    end
    checks++;
    if (clock !== 4'h0) begin errors++; $display("FAIL reset_clock: got %h want 0", clock); end
  endtask

  task automatic test_steering();
    logic [11:0] vec [4];
    vec[0] = 12'h087; vec[1] = 12'h1FC; vec[2] = 12'h269; vec[3] = 12'h3A5;
    select = 8'hF0;
    tick();
    checks++;
    if (clock !== 4'hF) begin errors++; $display("FAIL steer_clock: got %h want F", clock); end
    wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      instruction = vec[i];
      #1;
      checks++;
      if ({wr_en3, wr_en2, wr_en1, wr_en0} !== 4'b0001) begin
        errors++; $display("FAIL steer_strobe%0d: got %b want 0001", i, {wr_en3, wr_en2, wr_en1, wr_en0});
      end
      tick();
    end
    wr_en = 1'b0;
    checks++;
    if (fifo_counter0 !== 3'd4) begin errors++; $display("FAIL steer_count0: got %0d want 4", fifo_counter0); end
    checks++;
    if (data_full !== 4'b0001) begin errors++; $display("FAIL steer_full: got %b want 0001", data_full); end
    checks++;
    if (data_empty !== 4'b1110) begin errors++; $display("FAIL steer_empty: got %b want 1110", data_empty); end
    checks++;
    if (counter !== 5'd4) begin errors++; $display("FAIL steer_counter: got %0d want 4", counter); end
  endtask

  task automatic test_overflow();
    wr_en = 1'b1; rd_en = 1'b0; instruction = 12'h0FF;
    tick();
    wr_en = 1'b0;
    checks++;
    if (fifo_counter0 !== 3'd4) begin errors++; $display("FAIL overflow_count0: got %0d want 4", fifo_counter0); end
    checks++;
    if (counter !== 5'd4) begin errors++; $display("FAIL overflow_counter: got %0d want 4", counter); end
  endtask

  task automatic test_divide();
    // 8/7=1, 31/12=2, 38/9=4, 58/5=11; the dropped 0x0FF must never appear.
    logic [11:0] ins [4];
    logic [7:0]  quo [4];
    ins[0] = 12'h087; ins[1] = 12'h1FC; ins[2] = 12'h269; ins[3] = 12'h3A5;
    quo[0] = 8'h01;   quo[1] = 8'h02;   quo[2] = 8'h04;   quo[3] = 8'h0B;
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (result0 !== quo[i]) begin errors++; $display("FAIL divide_result%0d: got %h want %h", i, result0, quo[i]); end
      checks++;
      if (data_out0 !== ins[i]) begin errors++; $display("FAIL divide_data%0d: got %h want %h", i, data_out0, ins[i]); end
      checks++;
      if (fifo_counter0 !== 3'(3 - i)) begin errors++; $display("FAIL divide_count%0d: got %0d want %0d", i, fifo_counter0, 3 - i); end
    end
    checks++;
    if (data_empty[0] !== 1'b1) begin errors++; $display("FAIL divide_empty: got %b want 1", data_empty[0]); end
    tick();
    checks++;
    if (result0 !== 8'h0B) begin errors++; $display("FAIL divide_hold: got %h want 0b", result0); end
    checks++;
    if (data_out0 !== 12'h3A5) begin errors++; $display("FAIL divide_hold_data: got %h want 3a5", data_out0); end
  endtask

  task automatic test_core_enable();
    select = 8'hD0; rd_en = 1'b1;
    tick();
    wr_en = 1'b1; instruction = 12'h4B7;   // core 1, 11/7
    #1;
    checks++;
    if ({wr_en3, wr_en2, wr_en1, wr_en0} !== 4'b0010) begin
      errors++; $display("FAIL enable_strobe: got %b want 0010", {wr_en3, wr_en2, wr_en1, wr_en0});
    end
    tick();
    wr_en = 1'b0;
    tick();
    checks++;
    if (fifo_counter1 !== 3'd1) begin errors++; $display("FAIL enable_nopop: got %0d want 1", fifo_counter1); end
    checks++;
    if (result1 !== 8'h00) begin errors++; $display("FAIL enable_result_idle: got %h want 00", result1); end
    select = 8'hF0;
    tick();
    checks++;
    if (clock !== 4'hF) begin errors++; $display("FAIL enable_clock: got %h want F", clock); end
    checks++;
    if (fifo_counter1 !== 3'd1) begin errors++; $display("FAIL enable_latency: got %0d want 1", fifo_counter1); end
    tick();
    checks++;
    if (result1 !== 8'h01) begin errors++; $display("FAIL enable_result: got %h want 01", result1); end
    checks++;
    if (data_out1 !== 12'h4B7) begin errors++; $display("FAIL enable_data: got %h want 4b7", data_out1); end
    checks++;
    if (fifo_counter1 !== 3'd0) begin errors++; $display("FAIL enable_drain: got %0d want 0", fifo_counter1); end
  endtask

  task automatic test_div_zero_concurrency();
    logic [11:0] fill [4];
    rd_en = 1'b1; wr_en = 1'b1;
    instruction = 12'hC52;                 // core 3, 5/2 (pushed while empty: no pop)
    tick();
    checks++;
    if (fifo_counter3 !== 3'd1) begin errors++; $display("FAIL conc_push_empty: got %0d want 1", fifo_counter3); end
    instruction = 12'h920;                 // core 2, 18/0, while core 3 pops
    tick();
    wr_en = 1'b0;
    checks++;
    if (result3 !== 8'h02) begin errors++; $display("FAIL conc_result3: got %h want 02", result3); end
    checks++;
    if (fifo_counter2 !== 3'd1) begin errors++; $display("FAIL conc_count2: got %0d want 1", fifo_counter2); end
    tick();
    checks++;
    if (result2 !== 8'hFF) begin errors++; $display("FAIL div_zero_result2: got %h want ff", result2); end
    checks++;
    if (data_out2 !== 12'h920) begin errors++; $display("FAIL div_zero_data2: got %h want 920", data_out2); end

    // Fill core 3, then push and pop together while full.
    fill[0] = 12'hC64; fill[1] = 12'hCA2; fill[2] = 12'hCF3; fill[3] = 12'hD05;
    rd_en = 1'b0; wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      instruction = fill[i];
      tick();
    end
    checks++;
    if (data_full !== 4'b1000) begin errors++; $display("FAIL full_before: got %b want 1000", data_full); end
    rd_en = 1'b1; instruction = 12'hFFF;   // 63/15
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++;
    if (fifo_counter3 !== 3'd4) begin errors++; $display("FAIL full_pushpop_count: got %0d want 4", fifo_counter3); end
    checks++;
    if (result3 !== 8'h01) begin errors++; $display("FAIL full_pushpop_result: got %h want 01", result3); end
    checks++;
    if (data_out3 !== 12'hC64) begin errors++; $display("FAIL full_pushpop_data: got %h want c64", data_out3); end

    // Reset mid-stream discards everything.
    rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; instruction = 12'h087;
    tick();
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    checks++;
    if (counter !== 5'd0) begin errors++; $display("FAIL midrst_counter: got %0d want 0", counter); end
    checks++;
    if ({fifo_counter3, fifo_counter2, fifo_counter1, fifo_counter0} !== 12'h0) begin
      errors++; $display("FAIL midrst_counts: got %0d %0d %0d %0d want 0", fifo_counter3, fifo_counter2, fifo_counter1, fifo_counter0);
    end
    checks++;
    if (data_empty !== 4'hF) begin errors++; $display("FAIL midrst_empty: got %h want F", data_empty); end
    checks++;
    if ({result0, result1, result2, result3} !== 32'h0) begin
      errors++; $display("FAIL midrst_results: got %h %h %h %h want 0", result0, result1, result2, result3);
    end
    checks++;
    if (clock !== 4'h0) begin errors++; $display("FAIL midrst_clock: got %h want 0", clock); end
  endtask

  initial begin
    test_reset();
    test_steering();
    test_overflow();
    test_divide();
    test_core_enable();
    test_div_zero_concurrency();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
